// File: rtl/sobel_pkg.sv
// Shared constants and the beat payload for the Sobel edge-threshold stage.
package sobel_pkg;

  localparam int unsigned IMG_W   = 512;
  localparam int unsigned IMG_H   = 512;
  localparam int unsigned MAG_W   = 11;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned PIX_MAX = 255;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             eol;
    logic             eof;
  } edge_beat_t;

endpackage

// File: rtl/sobel_skid2.sv
// Two-entry valid/ready skid buffer on edge_beat_t; head register drives the outputs.
module sobel_skid2
  import sobel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  edge_beat_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output edge_beat_t out_data
);

  logic [1:0] occ, occ_n;
  edge_beat_t head, head_n, tail, tail_n;
  logic       push, pop;

  // Next occupancy and entry contents; a full buffer never sees a push.
  always_comb begin
    push   = in_valid && in_ready;
    pop    = out_valid && out_ready;
    occ_n  = occ;
    head_n = head;
    tail_n = tail;
    case (occ)
      2'd0: begin
        if (push) begin
          head_n = in_data;
          occ_n  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_n = in_data;
        end else if (push) begin
          tail_n = in_data;
          occ_n  = 2'd2;
        end else if (pop) begin
          occ_n  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_n = tail;
          occ_n  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      head      <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      occ       <= occ_n;
      head      <= head_n;
      tail      <= tail_n;
      out_valid <= (occ_n != 2'd0);
      in_ready  <= (occ_n != 2'd2);
    end
  end

  assign out_data = head;

endmodule

// File: rtl/sobel_edge_thresh.sv
// Thresholds Sobel magnitudes into an 8-bit edge map with row/frame markers.
// Optional per-frame edge counter enabled by defining SOBEL_EDGE_COUNT_EN.
module sobel_edge_thresh #(
  parameter int unsigned COLS  = sobel_pkg::IMG_W - 2,
  parameter int unsigned ROWS  = sobel_pkg::IMG_H - 2,
  parameter int unsigned MAG_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [MAG_W-1:0] thresh,
  input  logic             bin_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pix,
  output logic             out_eol,
  output logic             out_eof
`ifdef SOBEL_EDGE_COUNT_EN
  ,
  output logic [19:0]      edge_count,
  output logic             edge_count_valid
`endif
);

  import sobel_pkg::*;

  localparam int unsigned CW = $clog2(COLS + 1);
  localparam int unsigned RW = $clog2(ROWS + 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [MAG_W-1:0] thr_q;
  logic             bin_q;
  logic             in_fire, last_col, last_row, is_edge;
  logic [PIX_W-1:0] sat;
  edge_beat_t       beat, out_beat;

  assign in_fire  = in_valid && in_ready;
  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));
  assign is_edge  = (in_mag >= thr_q);
  assign sat      = (in_mag > MAG_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : in_mag[PIX_W-1:0];

  always_comb begin
    beat     = '0;
    beat.pix = bin_q ? (is_edge ? '1 : '0) : sat;
    beat.eol = last_col;
    beat.eof = last_col && last_row;
  end

  // Raster position; threshold/mode only reload while idle at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      thr_q <= '0;
      bin_q <= 1'b0;
    end else if (in_fire) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else if (col == '0 && row == '0) begin
      thr_q <= thresh;
      bin_q <= bin_mode;
    end
  end

  sobel_skid2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_beat)
  );

  assign out_pix = out_beat.pix;
  assign out_eol = out_beat.eol;
  assign out_eof = out_beat.eof;

`ifdef SOBEL_EDGE_COUNT_EN
  localparam int unsigned EC_W = 20;

  logic [EC_W-1:0] ecnt, ecnt_inc;

  assign ecnt_inc = (is_edge && ecnt != '1) ? ecnt + EC_W'(1) : ecnt;

  // Saturating per-frame edge tally, published with a one-cycle strobe at eof.
  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt             <= '0;
      edge_count       <= '0;
      edge_count_valid <= 1'b0;
    end else begin
      edge_count_valid <= 1'b0;
      if (in_fire) begin
        if (beat.eof) begin
          edge_count       <= ecnt_inc;
          edge_count_valid <= 1'b1;
          ecnt             <= '0;
        end else begin
          ecnt <= ecnt_inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sobel_edge_thresh.sv
// Randomised bench for sobel_edge_thresh against a queue-based reference model.
module tb_sobel_edge_thresh;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 3;
  localparam int unsigned MW   = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mag = '0;
  logic [MW-1:0] thresh = '0;
  logic          bin_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_pix;
  logic          out_eol;
  logic          out_eof;
`ifdef SOBEL_EDGE_COUNT_EN
  logic [19:0]   edge_count;
  logic          edge_count_valid;
`endif

  sobel_edge_thresh #(.COLS(COLS), .ROWS(ROWS), .MAG_W(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .thresh    (thresh),
    .bin_mode  (bin_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    .edge_count       (edge_count),
    .edge_count_valid (edge_count_valid)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raster position, frame-latched settings, FIFO of pending beats.
  typedef struct { int pix; bit eol; bit eof; } mbeat_t;
  mbeat_t mq[$];
  mbeat_t olog[$];
  mbeat_t mb;
  int     mcol, mrow, mthr, m_ecnt, m_ec;
  bit     mbin, live, acc_flag, m_ev, ia, oa, me;

  always @(posedge clk) begin
    live     = 1'b1;
    acc_flag = 1'b0;
    m_ev     = 1'b0;
    if (rst) begin
      mq.delete();
      mcol = 0; mrow = 0; mthr = 0; mbin = 1'b0; m_ecnt = 0; m_ec = 0;
    end else begin
      ia = in_valid && (mq.size() < 2);
      oa = (mq.size() > 0) && out_ready;
      if (oa) olog.push_back(mq.pop_front());
      if (ia) begin
        me     = (int'(in_mag) >= mthr);
        mb.pix = mbin ? (me ? 255 : 0) : ((int'(in_mag) > 255) ? 255 : int'(in_mag));
        mb.eol = (mcol == COLS - 1);
        mb.eof = mb.eol && (mrow == ROWS - 1);
        mq.push_back(mb);
        acc_flag = 1'b1;
        if (me && m_ecnt < (1 << 20) - 1) m_ecnt++;
        if (mb.eof) begin
          m_ec = m_ecnt; m_ev = 1'b1; m_ecnt = 0;
        end
        mcol++;
        if (mcol == COLS) begin
          mcol = 0; mrow++;
          if (mrow == ROWS) mrow = 0;
        end
      end else if (mcol == 0 && mrow == 0) begin
        mthr = int'(thresh);
        mbin = bin_mode;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
        check("out_pix", 32'(out_pix), 32'(mq[0].pix));
        check("out_eol", 32'(out_eol), 32'(mq[0].eol));
        check("out_eof", 32'(out_eof), 32'(mq[0].eof));
      end
`ifdef SOBEL_EDGE_COUNT_EN
      check("edge_count_valid", 32'(edge_count_valid), 32'(m_ev));
      if (m_ev) check("edge_count", 32'(edge_count), 32'(m_ec));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int m);
    in_valid = 1'b1;
    in_mag   = MW'(m);
    for (int i = 0; i < 64; i++) begin
      step();
      if (acc_flag) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic int lpix(input int i);
    return (i < olog.size()) ? olog[i].pix : -1;
  endfunction

  function automatic int leol(input int i);
    return (i < olog.size()) ? int'(olog[i].eol) : -1;
  endfunction

  function automatic int leof(input int i);
    return (i < olog.size()) ? int'(olog[i].eof) : -1;
  endfunction

  int base, cnt;
  int f1[12] = '{100, 255, 2040, 7, 300, 0, 1, 254, 256, 1023, 64, 200};
  int ecm[12] = '{10, 3, 20, 9, 0, 11, 255, 1, 2, 5, 2047, 9};

  initial begin
    // Reset state
    idle(2);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_eol", 32'(out_eol), 32'd0);
    check("rst_out_eof", 32'(out_eof), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    idle(1);

    // Saturated mode, one full frame; first pixel one cycle after acceptance
    send(f1[0]);
    @(negedge clk);
    check("lat1_valid", 32'(out_valid), 32'd1);
    check("lat1_pix", 32'(out_pix), 32'd100);
    for (int i = 1; i < 12; i++) send(f1[i]);
    idle(3);
    check("f1_count", 32'(olog.size()), 32'd12);
    check("f1_pix0", 32'(lpix(0)), 32'd100);
    check("f1_pix1", 32'(lpix(1)), 32'd255);
    check("f1_pix2", 32'(lpix(2)), 32'd255);
    check("f1_eol2", 32'(leol(2)), 32'd0);
    check("f1_eol3", 32'(leol(3)), 32'd1);
    check("f1_eof3", 32'(leof(3)), 32'd0);
    check("f1_eol7", 32'(leol(7)), 32'd1);
    check("f1_eof7", 32'(leof(7)), 32'd0);
    check("f1_eol11", 32'(leol(11)), 32'd1);
    check("f1_eof11", 32'(leof(11)), 32'd1);

    // Binary mode, threshold boundary, mid-frame threshold change ignored
    base = olog.size();
    thresh = 11'd128; bin_mode = 1'b1;
    idle(1);
    send(127); send(128); send(129);
    thresh = 11'd0;
    for (int i = 0; i < 9; i++) send(5);
    idle(3);
    check("bin_127", 32'(lpix(base)), 32'd0);
    check("bin_128", 32'(lpix(base + 1)), 32'd255);
    check("bin_129", 32'(lpix(base + 2)), 32'd255);
    check("bin_thr_hold", 32'(lpix(base + 3)), 32'd0);
    check("bin_eof", 32'(leof(base + 11)), 32'd1);

    // Backpressure: exactly two accepted while out_ready is low
    base = olog.size();
    bin_mode = 1'b0;
    idle(1);
    out_ready = 1'b0; in_valid = 1'b1; in_mag = 11'd50; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (acc_flag) begin
        cnt++;
        in_mag = in_mag + 11'd1;
      end
    end
    check("stall_accepts", 32'(cnt), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(52 + i);
    idle(4);
    check("stall_count", 32'(olog.size() - base), 32'd12);
    check("stall_ord0", 32'(lpix(base)), 32'd50);
    check("stall_ord1", 32'(lpix(base + 1)), 32'd51);
    check("stall_ord2", 32'(lpix(base + 2)), 32'd52);

    // Reset mid-row with two beats buffered
    send(9);
    idle(2);
    out_ready = 1'b0;
    send(10); send(11);
    in_valid = 1'b1; in_mag = 11'd12;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(1);
    base = olog.size();
    for (int i = 0; i < 12; i++) send(i * 20);
    idle(3);
    check("rst_mid_eol2", 32'(leol(base + 2)), 32'd0);
    check("rst_mid_eol3", 32'(leol(base + 3)), 32'd1);
    check("rst_mid_eof11", 32'(leof(base + 11)), 32'd1);

`ifdef SOBEL_EDGE_COUNT_EN
    thresh = 11'd10; bin_mode = 1'b1;
    idle(1);
    for (int i = 0; i < 12; i++) send(ecm[i]);
    @(negedge clk);
    check("ec_pulse", 32'(edge_count_valid), 32'd1);
    check("ec_value", 32'(edge_count), 32'd5);
    @(negedge clk);
    check("ec_pulse_end", 32'(edge_count_valid), 32'd0);
    idle(2);
`endif

    // Randomised traffic with occasional setting changes and resets
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mag    = ($urandom_range(0, 1) != 0) ? MW'($urandom_range(0, 2047))
                                              : MW'($urandom_range(100, 300));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) thresh = MW'($urandom_range(90, 310));
      if ($urandom_range(0, 15) == 0) bin_mode = ~bin_mode;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_thresh.md
Name: sobel_edge_thresh

Overview:
- Downstream of the Sobel gradient stage. Consumes the per-pixel magnitude stream |Gx|+|Gy| (11 bit) and produces an 8-bit edge-map pixel stream with row and frame markers.
- Each pixel is either a saturated magnitude or a binary edge value (0/255), chosen by a mode input.
- Provides valid/ready flow control on both sides. A 2-entry skid buffer decouples the gradient stage from the file/display writer.

Parameters:
- COLS, 510, valid magnitude pixels per row (image width minus 2).
- ROWS, 510, valid magnitude rows per frame (image height minus 2).
- MAG_W, 11, input magnitude width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_mag holds a valid magnitude.
- in_ready  output  1  block accepts in_mag this cycle.
- in_mag  input  MAG_W  gradient magnitude |Gx|+|Gy|.
- thresh  input  MAG_W  edge threshold; sampled at frame start.
- bin_mode  input  1  1 = binary output, 0 = saturated magnitude; sampled at frame start.
- out_valid  output  1  out_pix valid.
- out_ready  input  1  downstream accepts out_pix.
- out_pix  output  8  edge-map pixel.
- out_eol  output  1  last pixel of row, qualified by out_valid.
- out_eof  output  1  last pixel of frame, qualified by out_valid.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high; the clock port is named clk and the reset port rst.
  - On reset: out_valid=0, out_pix=0, out_eol=0, out_eof=0, in_ready=1. Column/row counters, skid entries and latched thresh/bin_mode are cleared.
  - Reset asserted mid-frame discards all buffered pixels and restarts at col=0, row=0.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_valid, once asserted, holds with out_pix/out_eol/out_eof stable until the transfer completes.
- Pixel computation, performed at input acceptance:
  - sat = (in_mag > 255) ? 255 : in_mag[7:0].
  - edge = (in_mag >= thr_q), where thr_q is the latched threshold.
  - pix = bin_mode_q ? (edge ? 8'hFF : 8'h00) : sat.
  - A magnitude exactly equal to thr_q counts as an edge.
- Counters:
  - col counts 0..COLS-1 and row counts 0..ROWS-1, both advancing on input transfer.
  - At col==COLS-1 the pixel is tagged eol, col wraps to 0 and row increments.
  - At row==ROWS-1 && col==COLS-1 the pixel is tagged eof and both counters wrap to 0.
- Frame-start sampling:
  - thr_q and bin_mode_q load from thresh/bin_mode at the cycle where col==0 && row==0 and no input transfer is in progress.
  - They remain constant for the whole frame. Changes to thresh mid-frame have no effect until the next frame.
- Skid buffer:
  - Two entries {pix, eol, eof}. The head drives the outputs.
  - in_ready = (occupancy < 2), registered.
  - Latency: a pixel accepted at cycle N appears on out_* at cycle N+1 when the buffer was empty.
  - Simultaneous input and output transfer keeps occupancy unchanged. Order is strictly FIFO.
  - Full buffer (occupancy 2): in_ready=0; input is stalled, never dropped.
  - Empty buffer: out_valid=0.
- Throughput: 1 pixel/clk sustained when out_ready is held high.

Optional Feature:
- Macro SOBEL_EDGE_COUNT_EN.
- When defined:
  - Adds output edge_count (20 bit) and output edge_count_valid (1 bit).
  - edge_count increments per accepted pixel with edge=1, and saturates at 2^20-1.
  - At the eof input transfer, the final count (including that pixel) is latched to the edge_count output and edge_count_valid pulses for 1 cycle; the counter then clears.
  - Reset clears both outputs.
- When undefined: no such ports or logic exist.

Decomposition:
- Package sobel_pkg holds:
  - constants IMG_W=512, IMG_H=512, MAG_W=11, PIX_W=8, PIX_MAX=255;
  - struct edge_beat_t {pix, eol, eof}.
- One natural sub-module: sobel_skid2, a generic 2-entry valid/ready skid buffer on edge_beat_t.

Test Plan:
- Reset, then stream 3 pixels with out_ready=1, bin_mode=0, in_mag={100, 255, 2040} -> out_pix={100, 255, 255}, each 1 cycle after acceptance; in_ready stays 1.
- bin_mode=1, thresh=128, in_mag={127, 128, 129} -> out_pix={00, FF, FF}. Change thresh to 0 mid-frame -> results unchanged until the next frame.
- out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 pixels accepted; in_ready=0 from the cycle after the 2nd acceptance. Release -> order preserved, no loss or duplication.
- Full frame with COLS=4, ROWS=3 -> out_eol on pixels 4, 8, 12; out_eof only on pixel 12; the next frame restarts at col=0.
- Assert rst for 1 cycle while 2 pixels are buffered mid-row -> out_valid=0 the next cycle; the next accepted pixel is col 0, row 0.
- With SOBEL_EDGE_COUNT_EN, bin_mode=1, thresh=10, frame 4x3 with 5 magnitudes ≥10 -> edge_count=5 with a 1-cycle edge_count_valid pulse after eof.
